// File: rtl/demux_dispatcher.sv
// One-word-per-channel 1:4 dispatcher: routes an input stream to four buffered
// output channels, either by explicit address or in strict round-robin order.
module demux_dispatcher #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [1:0]      in_sel,
    input  logic            mode,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready,
    output logic [4*DW-1:0] out_data,
    output logic            s1,
    output logic            s0,
    output logic [15:0]     accept_cnt
);

    logic [DW-1:0] data_q [4];
    logic [3:0]    full_q;
    logic [1:0]    rr_ptr;
    logic [1:0]    target;
    logic          accept;
    logic [3:0]    drain;

    // Round-robin never skips a busy channel, so the target is just the pointer.
    assign target   = mode ? rr_ptr : in_sel;
    assign in_ready = !full_q[target] | out_ready[target];
    assign accept   = in_valid & in_ready;
    assign drain    = full_q & out_ready;

    assign out_valid = full_q;

    always_comb begin
        out_data = '0;
        for (int n = 0; n < 4; n++) begin
            out_data[n*DW +: DW] = data_q[n];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q     <= '0;
            rr_ptr     <= '0;
            s1         <= 1'b0;
            s0         <= 1'b0;
            accept_cnt <= '0;
            for (int n = 0; n < 4; n++) begin
                data_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                // A fill on the same edge as a drain keeps the channel full with no bubble.
                if (accept && (target == 2'(n))) begin
                    data_q[n] <= in_data;
                    full_q[n] <= 1'b1;
                end else if (drain[n]) begin
                    full_q[n] <= 1'b0;
                end
            end
            if (accept) begin
                {s1, s0}   <= target;
                accept_cnt <= accept_cnt + 16'd1;
                if (mode) begin
                    rr_ptr <= rr_ptr + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_dispatcher.sv
// Bench for demux_dispatcher: directed vector table, hand-written corner
// sequences and a randomized run against a per-channel occupancy model.
module tb_demux_dispatcher;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic [1:0]  in_sel = '0;
    logic        mode = 1'b0;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
    logic [31:0] out_data;
    logic        s1;
    logic        s0;
    logic [15:0] accept_cnt;

    demux_dispatcher #(.DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .s1         (s1),
        .s0         (s0),
        .accept_cnt (accept_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: each channel is a one-entry slot; counters are plain integers.
    bit       m_full [4];
    bit [7:0] m_data [4];
    int       m_rr;
    int       m_last;
    int       m_cnt;
    logic     last_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            m_full[n] = 1'b0;
            m_data[n] = 8'h00;
        end
        m_rr = 0;
        m_last = 0;
        m_cnt = 0;
    endtask

    // Called at posedge+1; applies inputs for one clock and checks the result.
    task automatic cycle(input logic v, input logic [7:0] d, input logic [1:0] sel,
                         input logic md, input logic [3:0] ordy);
        int  tgt;
        bit  rdy;
        bit  acc;
        in_valid  = v;
        in_data   = d;
        in_sel    = sel;
        mode      = md;
        out_ready = ordy;
        #1;
        tgt = md ? m_rr : int'(sel);
        rdy = !m_full[tgt] || ordy[tgt];
        acc = v && rdy;
        last_ready = in_ready;
        chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
        @(posedge clk);
        #1;
        for (int n = 0; n < 4; n++) begin
            if (m_full[n] && ordy[n]) m_full[n] = 1'b0;
        end
        if (acc) begin
            m_full[tgt] = 1'b1;
            m_data[tgt] = d;
            m_last = tgt;
            m_cnt = (m_cnt + 1) % 65536;
            if (md) m_rr = (m_rr + 1) % 4;
        end
        chk("out_valid", {28'b0, out_valid},
            {28'b0, m_full[3], m_full[2], m_full[1], m_full[0]});
        chk("out_data", out_data, {m_data[3], m_data[2], m_data[1], m_data[0]});
        chk("sel_index", {30'b0, s1, s0}, 32'(m_last));
        chk("accept_cnt", {16'b0, accept_cnt}, 32'(m_cnt));
    endtask

    // Asserts rst between edges, checks the immediate clear, holds a word on
    // the input across an edge while in reset, then releases between edges.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_out_valid", {28'b0, out_valid}, 32'h0);
        chk("rst_accept_cnt", {16'b0, accept_cnt}, 32'h0);
        chk("rst_sel_index", {30'b0, s1, s0}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        in_valid = 1'b1;
        in_data = 8'h5A;
        mode = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        chk("rst_no_accept", {16'b0, accept_cnt}, 32'h0);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic [1:0]  sel;
        logic        md;
        logic [3:0]  ordy;
        logic        rdy;
        logic [3:0]  ov;
        logic [1:0]  s;
        logic [15:0] cnt;
        logic [31:0] od;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // Addressed sweep then round-robin wrap; sel is ignored in round-robin.
        tbl[0]  = '{1'b1, 8'hA1, 2'd0, 1'b0, 4'hF, 1'b1, 4'b0001, 2'd0, 16'd1,  32'h000000A1};
        tbl[1]  = '{1'b1, 8'hA2, 2'd1, 1'b0, 4'hF, 1'b1, 4'b0010, 2'd1, 16'd2,  32'h0000A2A1};
        tbl[2]  = '{1'b1, 8'hA3, 2'd2, 1'b0, 4'hF, 1'b1, 4'b0100, 2'd2, 16'd3,  32'h00A3A2A1};
        tbl[3]  = '{1'b1, 8'hA4, 2'd3, 1'b0, 4'hF, 1'b1, 4'b1000, 2'd3, 16'd4,  32'hA4A3A2A1};
        tbl[4]  = '{1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 1'b1, 4'b0000, 2'd3, 16'd4,  32'hA4A3A2A1};
        tbl[5]  = '{1'b1, 8'hB0, 2'd0, 1'b1, 4'hF, 1'b1, 4'b0001, 2'd0, 16'd5,  32'hA4A3A2B0};
        tbl[6]  = '{1'b1, 8'hB1, 2'd3, 1'b1, 4'hF, 1'b1, 4'b0010, 2'd1, 16'd6,  32'hA4A3B1B0};
        tbl[7]  = '{1'b1, 8'hB2, 2'd0, 1'b1, 4'hF, 1'b1, 4'b0100, 2'd2, 16'd7,  32'hA4B2B1B0};
        tbl[8]  = '{1'b1, 8'hB3, 2'd0, 1'b1, 4'hF, 1'b1, 4'b1000, 2'd3, 16'd8,  32'hB3B2B1B0};
        tbl[9]  = '{1'b1, 8'hB4, 2'd2, 1'b1, 4'hF, 1'b1, 4'b0001, 2'd0, 16'd9,  32'hB3B2B1B4};
        tbl[10] = '{1'b1, 8'hB5, 2'd0, 1'b1, 4'hF, 1'b1, 4'b0010, 2'd1, 16'd10, 32'hB3B2B5B4};
        tbl[11] = '{1'b1, 8'hB6, 2'd0, 1'b1, 4'hF, 1'b1, 4'b0100, 2'd2, 16'd11, 32'hB3B6B5B4};
        tbl[12] = '{1'b0, 8'hFF, 2'd1, 1'b1, 4'hF, 1'b1, 4'b0000, 2'd2, 16'd11, 32'hB3B6B5B4};

        model_reset();
        do_reset();

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].sel, tbl[i].md, tbl[i].ordy);
            chk($sformatf("tbl%0d_ready", i), {31'b0, last_ready}, {31'b0, tbl[i].rdy});
            chk($sformatf("tbl%0d_valid", i), {28'b0, out_valid}, {28'b0, tbl[i].ov});
            chk($sformatf("tbl%0d_sel", i), {30'b0, s1, s0}, {30'b0, tbl[i].s});
            chk($sformatf("tbl%0d_cnt", i), {16'b0, accept_cnt}, {16'b0, tbl[i].cnt});
            chk($sformatf("tbl%0d_data", i), out_data, tbl[i].od);
        end

        // Backpressure on channel 2 must not block channel 1.
        do_reset();
        cycle(1'b1, 8'h55, 2'd2, 1'b0, 4'b1011);
        cycle(1'b1, 8'h66, 2'd2, 1'b0, 4'b1011);
        chk("bp_ready_low", {31'b0, last_ready}, 32'h0);
        chk("bp_hold_55", {24'b0, out_data[23:16]}, 32'h55);
        cycle(1'b1, 8'h77, 2'd1, 1'b0, 4'b1011);
        chk("bp_other_ready", {31'b0, last_ready}, 32'h1);
        chk("bp_other_data", {24'b0, out_data[15:8]}, 32'h77);
        chk("bp_still_55", {24'b0, out_data[23:16]}, 32'h55);
        cycle(1'b1, 8'h66, 2'd2, 1'b0, 4'b1111);
        chk("bp_release_ready", {31'b0, last_ready}, 32'h1);
        chk("bp_no_bubble", {31'b0, out_valid[2]}, 32'h1);
        chk("bp_new_word", {24'b0, out_data[23:16]}, 32'h66);

        // Round-robin stalls on a full channel 0 instead of skipping it.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'(8'hC0 + i), 2'd0, 1'b1, 4'b1110);
        end
        chk("rr_ch0_held", {28'b0, out_valid}, 32'b1001);
        cycle(1'b1, 8'hC4, 2'd0, 1'b1, 4'b1110);
        chk("rr_stall1", {31'b0, last_ready}, 32'h0);
        cycle(1'b1, 8'hC4, 2'd0, 1'b1, 4'b1110);
        chk("rr_stall2", {31'b0, last_ready}, 32'h0);
        chk("rr_stall_cnt", {16'b0, accept_cnt}, 32'd4);
        cycle(1'b1, 8'hC4, 2'd0, 1'b1, 4'b1111);
        chk("rr_unstall", {31'b0, last_ready}, 32'h1);
        chk("rr_land_ch0", {24'b0, out_data[7:0]}, 32'hC4);
        chk("rr_land_sel", {30'b0, s1, s0}, 32'h0);

        // Reset with channels 1 and 3 holding words, then round-robin starts at 0.
        do_reset();
        cycle(1'b1, 8'h11, 2'd1, 1'b0, 4'b0000);
        cycle(1'b1, 8'h33, 2'd3, 1'b0, 4'b0000);
        chk("mid_filled", {28'b0, out_valid}, 32'b1010);
        do_reset();
        cycle(1'b1, 8'hE0, 2'd2, 1'b1, 4'b1111);
        chk("post_rst_ch0", {28'b0, out_valid}, 32'b0001);
        chk("post_rst_data", {24'b0, out_data[7:0]}, 32'hE0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom),
                  1'($urandom), 4'($urandom));
        end

        // Counter wrap after 65535 accepts.
        do_reset();
        in_valid = 1'b1;
        mode = 1'b1;
        out_ready = 4'hF;
        repeat (65535) @(posedge clk);
        #1;
        chk("cnt_ffff", {16'b0, accept_cnt}, 32'hFFFF);
        chk("cnt_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        chk("cnt_wrap", {16'b0, accept_cnt}, 32'h0);
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_dispatcher.md
DEMUX_DISPATCHER -- requirements
Module: demux_dispatcher

Interface
REQ-001 SHALL provide parameter: DW, 8, data width of input and of each output channel.
REQ-002 SHALL provide port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port: in_valid  input  1  upstream word present.
REQ-005 SHALL provide port: in_ready  output  1  dispatcher can accept the word this cycle.
REQ-006 SHALL provide port: in_data  input  DW  word to route.
REQ-007 SHALL provide port: in_sel  input  2  target channel in addressed mode (in_sel[1]=s1, in_sel[0]=s0).
REQ-008 SHALL provide port: mode  input  1  0 = addressed by in_sel, 1 = round-robin.
REQ-009 SHALL provide port: out_valid  output  4  per-channel valid, bit N = channel N.
REQ-010 SHALL provide port: out_ready  input  4  per-channel consumer ready.
REQ-011 SHALL provide port: out_data  output  4*DW  channel N at bits [N*DW +: DW].
REQ-012 SHALL provide port: s1, s0  output  1 each  registered index of the last accepted channel, for a downstream 1:4 demux.
REQ-013 SHALL provide port: accept_cnt  output  16  count of accepted words.

Function
REQ-014 SHALL hold one DW-bit buffer plus a full flag per channel; out_valid[N] = full flag N.
REQ-015 SHALL use target = in_sel when mode=0, target = rr_ptr (2-bit) when mode=1; mode and in_sel act combinationally in the cycle.
REQ-016 SHALL drive in_ready = !full[target] | out_ready[target] (combinational, no dependency on in_valid).
REQ-017 SHALL accept when in_valid & in_ready: buffer[target] <= in_data, full[target] <= 1 at next edge; latency input-to-out_valid exactly 1 cycle.
REQ-018 SHALL drain channel N when out_valid[N] & out_ready[N]; full[N] clears at the next edge unless the same edge accepts a new word into N (simultaneous drain+fill: full stays 1, buffer takes new word, no bubble).
REQ-019 SHALL keep out_data for channel N stable while out_valid[N]=1 and out_ready[N]=0.
REQ-020 SHALL let channels drain independently; a stalled channel SHALL NOT block accepts to other channels in addressed mode.
REQ-021 SHALL advance rr_ptr by 1 modulo 4 on each accept with mode=1 (3 wraps to 0); rr_ptr SHALL hold when no accept or mode=0.
REQ-022 SHALL, in round-robin mode, stall (in_ready=0) while the channel at rr_ptr is full and not draining; rr_ptr SHALL NOT skip busy channels.
REQ-023 SHALL on each accept register {s1,s0} <= target; otherwise hold.
REQ-024 SHALL increment accept_cnt by 1 per accept, wrapping 0xFFFF to 0x0000.
REQ-025 SHALL ignore in_data, in_sel when in_valid=0; no state changes without accept or drain.

Reset
REQ-026 SHALL on rst=1, immediately and independent of clk, clear: all full flags (out_valid=4'b0000), rr_ptr=0, s1=0, s0=0, accept_cnt=0; buffers SHALL reset to 0 (out_data=0).
REQ-027 SHALL discard any word presented or buffered when rst asserts mid-transfer; first accept after rst deassertion SHALL go to in_sel (mode=0) or channel 0 (mode=1).
REQ-028 SHALL drive in_ready from reset state while rst=1 but SHALL NOT accept while rst=1.

Verification
REQ-029 Addressed: mode=0, out_ready=4'b1111, send 0xA1..0xA4 with in_sel 0,1,2,3 back-to-back -> out_valid one-hot 0001,0010,0100,1000 one cycle after each, {s1,s0}=0,1,2,3, accept_cnt=4.
REQ-030 Round-robin wrap: mode=1, out_ready=4'b1111, send 6 words -> channels 0,1,2,3,0,1; rr_ptr ends at 2; in_ready constantly 1.
REQ-031 Backpressure: mode=0, out_ready[2]=0, send 0x55 then 0x66 to channel 2 -> 0x55 held on channel 2, in_ready=0 for second word; word to in_sel=1 accepted meanwhile; raise out_ready[2] -> 0x66 accepted same cycle, no bubble.
REQ-032 RR stall: mode=1, out_ready[0]=0, send 5 words -> 4 accepted (ch0..3), 5th stalls with in_ready=0 until out_ready[0]=1, then lands in ch0.
REQ-033 Reset mid-operation: fill channels 1 and 3, assert rst asynchronously between edges -> out_valid=0000, accept_cnt=0, {s1,s0}=00 immediately; after release mode=1 first word goes to ch0.
REQ-034 Counter wrap: preload by 65535 accepts, one more accept -> accept_cnt=0x0000.
